datapath_scheduler: RTL and testbench

DATAPATH_SCHEDULER -- requirements
Module: datapath_scheduler

---
 rtl/datapath_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_datapath_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_scheduler.sv
// -----------------------------------------------------------------------------
// datapath_scheduler
//
// Purpose: shares one datapath between a host instruction port and an internal
// raster refresh requester. A four-state FSM (IDLE, ISSUE, WAIT_LO, WAIT_HI)
// issues one instruction at a time and waits for the datapath's finished flag
// to fall and rise again. If the flag never falls, the wait is cut short after
// TIMEOUT cycles. Arbitration is round-robin between host and refresh.
//
// Handshakes:
//   host_req/host_instr are held by the host until host_ack. host_ack pulses in
//   the ISSUE cycle, and host_done pulses when the instruction has completed.
//   dp_start pulses for one cycle with dp_instruction. dp_finished is then
//   expected to go low (busy) and return high (done).
//
// Ports:
//   clock, resetn           clock, synchronous active-low reset
//   host_req, host_instr    host request and instruction
//   host_ack, host_done     host handshake pulses
//   host_result             dp_result captured at host completion
//   refresh_en              enables the raster refresh requester
//   frame_done              pulse after the last pixel of a frame completes
//   dp_start, dp_instruction  datapath issue interface
//   dp_finished, dp_result  datapath status and result
//   busy, grant_host        FSM not idle / in-flight instruction is the host's
//   timeout_err             sticky forced-completion flag
//   dbg_state               current FSM state, for debug
// -----------------------------------------------------------------------------
module datapath_scheduler #(
   parameter int         SCREEN_W       = 160,
   parameter int         SCREEN_H       = 120,
   parameter logic [3:0] OPCODE_DISPLAY = 4'd3,
   parameter int         TIMEOUT        = 8
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        host_req,
   input  logic [31:0] host_instr,
   output logic        host_ack,
   output logic        host_done,
   output logic [11:0] host_result,
   input  logic        refresh_en,
   output logic        frame_done,
   output logic        dp_start,
   output logic [31:0] dp_instruction,
   input  logic        dp_finished,
   input  logic [11:0] dp_result,
   output logic        busy,
   output logic        grant_host,
   output logic        timeout_err,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT_LO = 2'd2;
   localparam logic [1:0] WAIT_HI = 2'd3;

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    state_q, state_d;
   logic [7:0]    x_q, x_d;
   logic [6:0]    y_q, y_d;
   logic          last_host_q, last_host_d;   // 1: host was served last
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          host_ack_q, host_ack_d;
   logic          host_done_q, host_done_d;
   logic [11:0]   host_result_q, host_result_d;
   logic          frame_done_q, frame_done_d;
   logic          dp_start_q, dp_start_d;
   logic [31:0]   dp_instr_q, dp_instr_d;
   logic          busy_q, busy_d;
   logic          grant_host_q, grant_host_d;
   logic          timeout_err_q, timeout_err_d;

   logic          host_win;
   logic          complete;
   logic [31:0]   refresh_instr;

   // The host wins when it is alone or when refresh was served last.
   assign host_win      = host_req && (!refresh_en || !last_host_q);
   assign refresh_instr = {13'd0, y_q, x_q, OPCODE_DISPLAY};

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      last_host_d   = last_host_q;
      to_cnt_d      = to_cnt_q;
      host_ack_d    = 1'b0;
      host_done_d   = 1'b0;
      host_result_d = host_result_q;
      frame_done_d  = 1'b0;
      dp_start_d    = 1'b0;
      dp_instr_d    = dp_instr_q;
      busy_d        = busy_q;
      grant_host_d  = grant_host_q;
      timeout_err_d = timeout_err_q;
      complete      = 1'b0;

      case (state_q)
         IDLE: begin
            if (dp_finished && (host_req || refresh_en)) begin
               state_d      = ISSUE;
               dp_start_d   = 1'b1;
               busy_d       = 1'b1;
               grant_host_d = host_win;
               host_ack_d   = host_win;
               last_host_d  = host_win;
               dp_instr_d   = host_win ? host_instr : refresh_instr;
            end
         end
         ISSUE: begin
            state_d  = WAIT_LO;
            to_cnt_d = '0;
         end
         WAIT_LO: begin
            if (!dp_finished) begin
               state_d = WAIT_HI;
            end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
               // Datapath never acknowledged the start: force completion.
               complete      = 1'b1;
               timeout_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         WAIT_HI: begin
            if (dp_finished) begin
               complete = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Completion always returns to IDLE, so a new issue needs one IDLE cycle.
      if (complete) begin
         state_d      = IDLE;
         busy_d       = 1'b0;
         grant_host_d = 1'b0;
         if (grant_host_q) begin
            host_result_d = dp_result;
            host_done_d   = 1'b1;
         end else if (x_q == 8'(SCREEN_W - 1)) begin
            x_d = '0;
            if (y_q == 7'(SCREEN_H - 1)) begin
               y_d          = '0;
               frame_done_d = 1'b1;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         last_host_q   <= 1'b0;
         to_cnt_q      <= '0;
         host_ack_q    <= 1'b0;
         host_done_q   <= 1'b0;
         host_result_q <= '0;
         frame_done_q  <= 1'b0;
         dp_start_q    <= 1'b0;
         dp_instr_q    <= '0;
         busy_q        <= 1'b0;
         grant_host_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         last_host_q   <= last_host_d;
         to_cnt_q      <= to_cnt_d;
         host_ack_q    <= host_ack_d;
         host_done_q   <= host_done_d;
         host_result_q <= host_result_d;
         frame_done_q  <= frame_done_d;
         dp_start_q    <= dp_start_d;
         dp_instr_q    <= dp_instr_d;
         busy_q        <= busy_d;
         grant_host_q  <= grant_host_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign host_ack       = host_ack_q;
   assign host_done      = host_done_q;
   assign host_result    = host_result_q;
   assign frame_done     = frame_done_q;
   assign dp_start       = dp_start_q;
   assign dp_instruction = dp_instr_q;
   assign busy           = busy_q;
   assign grant_host     = grant_host_q;
   assign timeout_err    = timeout_err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_datapath_scheduler.sv
// -----------------------------------------------------------------------------
// tb_datapath_scheduler
//
// Bench for datapath_scheduler with a 4x2 screen and TIMEOUT of 8. A
// transaction-level model predicts the grants, instructions, completions and
// raster position from the sampled inputs. It is compared against the DUT on
// every falling edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_datapath_scheduler;

   localparam int         W   = 4;
   localparam int         H   = 2;
   localparam int         TO  = 8;
   localparam logic [3:0] OPC = 4'd3;

   // ---------------- clock / reset / DUT ----------------
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        host_req = 1'b0;
   logic [31:0] host_instr = '0;
   logic        refresh_en = 1'b0;
   logic        dp_finished = 1'b1;
   logic [11:0] dp_result = '0;
   logic        host_ack, host_done, frame_done, dp_start, busy, grant_host, timeout_err;
   logic [11:0] host_result;
   logic [31:0] dp_instruction;
   logic [1:0]  dbg_state;

   always #5 clock = ~clock;

   datapath_scheduler #(.SCREEN_W(W), .SCREEN_H(H), .OPCODE_DISPLAY(OPC), .TIMEOUT(TO)) dut (
      .clock(clock), .resetn(resetn),
      .host_req(host_req), .host_instr(host_instr),
      .host_ack(host_ack), .host_done(host_done), .host_result(host_result),
      .refresh_en(refresh_en), .frame_done(frame_done),
      .dp_start(dp_start), .dp_instruction(dp_instruction),
      .dp_finished(dp_finished), .dp_result(dp_result),
      .busy(busy), .grant_host(grant_host), .timeout_err(timeout_err),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;
   int n_issue = 0, n_ack = 0, n_done = 0, n_frame = 0;
   time t_ack = 0, t_done = 0;
   logic [31:0] log_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- datapath model ----------------
   int          low_len = 1;
   bit          never_drop = 1'b0;
   logic [11:0] res_val = '0;

   initial begin : dp_model
      forever begin
         @(negedge clock);
         if (dp_start === 1'b1) begin
            @(posedge clock);
            #1;
            dp_result = res_val;
            if (!never_drop) begin
               dp_finished = 1'b0;
               repeat (low_len) @(posedge clock);
               #1;
               dp_finished = 1'b1;
            end
         end
      end
   end

   // ---------------- input sampling at the active edge ----------------
   logic        s_rst = 1'b0, s_hreq = 1'b0, s_ref = 1'b0, s_fin = 1'b1;
   logic [31:0] s_hinstr = '0;
   logic [11:0] s_res = '0;

   initial begin : sampler
      forever begin
         @(posedge clock);
         s_rst    = resetn;
         s_hreq   = host_req;
         s_ref    = refresh_en;
         s_fin    = dp_finished;
         s_hinstr = host_instr;
         s_res    = dp_result;
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   initial begin : model_compare
      bit          m_busy, m_host, m_first, m_low_seen, m_last_host, m_to;
      bit          e_start, e_ack, e_done, e_frame, complete, hw;
      int          m_lo_cnt, m_x, m_y;
      logic [11:0] m_result;
      logic [31:0] m_instr;
      m_busy = 0; m_host = 0; m_first = 0; m_low_seen = 0; m_last_host = 0; m_to = 0;
      m_lo_cnt = 0; m_x = 0; m_y = 0; m_result = '0; m_instr = '0;
      forever begin
         @(negedge clock);
         e_start = 0; e_ack = 0; e_done = 0; e_frame = 0; complete = 0;
         if (!s_rst) begin
            m_busy = 0; m_host = 0; m_x = 0; m_y = 0; m_last_host = 0;
            m_to = 0; m_result = '0; m_instr = '0;
         end else if (m_busy) begin
            if (m_first) begin
               m_first = 0;
            end else if (!m_low_seen) begin
               if (!s_fin) m_low_seen = 1;
               else begin
                  m_lo_cnt++;
                  if (m_lo_cnt == TO) begin complete = 1; m_to = 1; end
               end
            end else if (s_fin) begin
               complete = 1;
            end
            if (complete) begin
               m_busy = 0;
               if (m_host) begin
                  m_result = s_res;
                  e_done = 1;
               end else begin
                  m_x++;
                  if (m_x == W) begin
                     m_x = 0;
                     m_y++;
                     if (m_y == H) begin m_y = 0; e_frame = 1; end
                  end
               end
            end
         end else if (s_fin && (s_hreq || s_ref)) begin
            hw = s_hreq && (!s_ref || !m_last_host);
            m_busy = 1; m_first = 1; m_low_seen = 0; m_lo_cnt = 0;
            m_host = hw; m_last_host = hw; e_start = 1; e_ack = hw;
            m_instr = hw ? s_hinstr : {13'd0, 7'(m_y), 8'(m_x), OPC};
         end

         chk("dp_start", {31'd0, dp_start}, {31'd0, e_start});
         chk("host_ack", {31'd0, host_ack}, {31'd0, e_ack});
         chk("host_done", {31'd0, host_done}, {31'd0, e_done});
         chk("frame_done", {31'd0, frame_done}, {31'd0, e_frame});
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("grant_host", {31'd0, grant_host}, {31'd0, m_busy && m_host});
         chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
         chk("host_result", {20'd0, host_result}, {20'd0, m_result});
         if (m_busy || !s_rst) chk("dp_instruction", dp_instruction, m_instr);

         if (dp_start === 1'b1) begin n_issue++; log_q.push_back(dp_instruction); end
         if (host_ack === 1'b1) begin n_ack++; t_ack = $time; end
         if (host_done === 1'b1) begin n_done++; t_done = $time; end
         if (frame_done === 1'b1) n_frame++;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic edge_drive();
      @(posedge clock);
      #2;
   endtask

   function automatic int cur_count(input int sel);
      case (sel)
         0: return n_issue;
         1: return n_ack;
         default: return n_done;
      endcase
   endfunction

   // Bounded wait on one of the monitor counters (0 issue, 1 ack, 2 done).
   task automatic wait_count(input int sel, input int target, input string nm);
      int k;
      int v;
      k = 0;
      v = cur_count(sel);
      while (v < target && k < 400) begin
         @(negedge clock);
         k++;
         v = cur_count(sel);
      end
      n_cmp++;
      if (v < target) begin
         n_err++;
         $display("FAIL wait_%s: count %0d, expected at least %0d", nm, v, target);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " host_ack"}, {31'd0, host_ack}, 32'd0);
      chk({nm, " host_done"}, {31'd0, host_done}, 32'd0);
      chk({nm, " host_result"}, {20'd0, host_result}, 32'd0);
      chk({nm, " frame_done"}, {31'd0, frame_done}, 32'd0);
      chk({nm, " dp_start"}, {31'd0, dp_start}, 32'd0);
      chk({nm, " dp_instruction"}, dp_instruction, 32'd0);
      chk({nm, " busy"}, {31'd0, busy}, 32'd0);
      chk({nm, " grant_host"}, {31'd0, grant_host}, 32'd0);
      chk({nm, " timeout_err"}, {31'd0, timeout_err}, 32'd0);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : main
      int d0;
      int s0;
      logic [31:0] exp_px;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_zero("reset");
      edge_drive();
      resetn = 1'b1;

      // Host only: finished low one cycle, result ABC
      res_val = 12'hABC; low_len = 1;
      host_instr = 32'h0000_1232; host_req = 1'b1;
      wait_count(1, 1, "t1_ack");
      edge_drive();
      host_req = 1'b0;
      wait_count(2, 1, "t1_done");
      repeat (2) edge_drive();
      chk("t1 host_result", {20'd0, host_result}, 32'h0000_0ABC);
      chk("t1 issues", n_issue, 1);
      chk("t1 instr", log_q[0], 32'h0000_1232);

      // Refresh only: full 4x2 frame, then wrap to (0,0); drop enable mid-flight
      refresh_en = 1'b1;
      wait_count(0, 10, "t2_issue");
      edge_drive();
      refresh_en = 1'b0;
      repeat (15) edge_drive();
      chk("t2 issues after disable", n_issue, 10);
      chk("t2 frame count", n_frame, 1);
      for (int i = 0; i < 9; i++) begin
         exp_px = {13'd0, 7'((i / W) % H), 8'(i % W), OPC};
         chk("t2 raster instr", log_q[1 + i], exp_px);
      end
      chk("t2 px(3,0)", log_q[4], 32'h0000_0033);
      chk("t2 px(3,1)", log_q[8], 32'h0000_1033);
      chk("t2 wrap px", log_q[9], 32'h0000_0003);

      // Both requesting: host first (refresh served last), then alternate
      host_instr = 32'h0000_A0A1; host_req = 1'b1; refresh_en = 1'b1;
      wait_count(0, 16, "t3_issue");
      edge_drive();
      host_req = 1'b0; refresh_en = 1'b0;
      repeat (12) edge_drive();
      chk("t3 grant0 host", log_q[10], 32'h0000_A0A1);
      chk("t3 grant1 px(1,0)", log_q[11], 32'h0000_0013);
      chk("t3 grant2 host", log_q[12], 32'h0000_A0A1);
      chk("t3 grant3 px(2,0)", log_q[13], 32'h0000_0023);
      chk("t3 grant4 host", log_q[14], 32'h0000_A0A1);
      chk("t3 grant5 px(3,0)", log_q[15], 32'h0000_0033);

      // Datapath never drops finished: forced completion, sticky error
      never_drop = 1'b1; res_val = 12'h5A5;
      host_instr = 32'h0000_7774; host_req = 1'b1;
      d0 = n_done;
      wait_count(1, n_ack + 1, "t4_ack");
      edge_drive();
      host_req = 1'b0;
      wait_count(2, d0 + 1, "t4_done");
      repeat (2) edge_drive();
      chk("t4 timeout_err", {31'd0, timeout_err}, 32'd1);
      chk("t4 host_result", {20'd0, host_result}, 32'h0000_05A5);
      chk("t4 ack-to-done cycles", 32'((t_done - t_ack) / 10), 32'd9);
      never_drop = 1'b0; res_val = 12'h123;
      host_instr = 32'h0000_0011; host_req = 1'b1;
      wait_count(1, n_ack + 1, "t4b_ack");
      edge_drive();
      host_req = 1'b0;
      wait_count(2, d0 + 2, "t4b_done");
      repeat (2) edge_drive();
      chk("t4 timeout_err sticky", {31'd0, timeout_err}, 32'd1);
      chk("t4b host_result", {20'd0, host_result}, 32'h0000_0123);

      // Reset during WAIT_HI of a host transaction
      low_len = 6; res_val = 12'hFFF;
      host_instr = 32'h0000_2222; host_req = 1'b1;
      wait_count(1, n_ack + 1, "t5_ack");
      edge_drive();
      host_req = 1'b0;
      repeat (2) edge_drive();
      d0 = n_done;
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_zero("mid-transaction reset");
      edge_drive();
      resetn = 1'b1;
      repeat (10) edge_drive();
      chk("t5 no host_done", n_done, d0);
      s0 = n_issue;
      host_instr = 32'h0000_3333; host_req = 1'b1; refresh_en = 1'b1; low_len = 1;
      wait_count(0, s0 + 2, "t5_issue");
      edge_drive();
      host_req = 1'b0; refresh_en = 1'b0;
      repeat (10) edge_drive();
      chk("t5 first grant host", log_q[s0], 32'h0000_3333);
      chk("t5 refresh restarts at (0,0)", log_q[s0 + 1], 32'h0000_0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
